// File: rtl/dmem_arbiter.sv
// dmem_arbiter: owns the single-port data RAM and serialises the pipeline
// port (M) and the loader/debug port (L) into a fixed IDLE -> ISSUE -> RESP
// access. Pipeline addresses beyond the RAM depth complete with m_err and
// never reach the RAM. A saturating wait counter forces an L grant after
// MAX_WAIT consecutive M grants made while L was pending.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m_req/m_we/m_addr/m_wdata  pipeline request (held until m_valid)
//   m_rdata/m_valid/m_err      pipeline response, registered
//   m_stall                    combinational stall, m_req && !m_valid
//   l_req/l_we/l_addr/l_wdata  loader request (held until l_valid)
//   l_rdata/l_valid            loader response, registered
//   mem_en/mem_we/mem_addr/mem_wdata  RAM command, registered (ISSUE cycle)
//   mem_rdata                  RAM read data, sampled on the edge ending ISSUE
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [63:0]       m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_valid,
  output logic              m_err,
  output logic              m_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {OWN_M, OWN_L} owner_t;

  state_t            state;
  owner_t            owner;
  logic [WAIT_W-1:0] l_wait;
  logic              lat_we;

  logic grant_l;
  logic grant_m;
  logic m_oob;

  // L wins only when alone or when it has waited out MAX_WAIT M grants.
  assign grant_l = l_req && (!m_req || (l_wait == WAIT_MAX));
  assign grant_m = m_req && !grant_l;
  assign m_oob   = |m_addr[63:ADDR_W];
  assign m_stall = m_req && !m_valid;

  // Sequencer; mem_addr/mem_wdata double as the latched request address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_M;
      l_wait    <= '0;
      lat_we    <= 1'b0;
      m_rdata   <= '0;
      l_rdata   <= '0;
      m_valid   <= 1'b0;
      l_valid   <= 1'b0;
      m_err     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      m_valid <= 1'b0;
      l_valid <= 1'b0;
      m_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_l) begin
            owner     <= OWN_L;
            lat_we    <= l_we;
            l_wait    <= '0;
            mem_en    <= 1'b1;
            mem_we    <= l_we;
            mem_addr  <= l_addr;
            mem_wdata <= l_wdata;
            state     <= ISSUE;
          end else if (grant_m) begin
            owner  <= OWN_M;
            lat_we <= m_we;
            if (l_req && (l_wait < WAIT_MAX)) begin
              l_wait <= l_wait + WAIT_W'(1);
            end
            if (m_oob) begin
              // Out-of-range: respond immediately, RAM untouched.
              m_valid <= 1'b1;
              m_err   <= 1'b1;
              state   <= RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= m_we;
              mem_addr  <= m_addr[ADDR_W-1:0];
              mem_wdata <= m_wdata;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (owner == OWN_L) begin
            l_valid <= 1'b1;
            if (!lat_we) begin
              l_rdata <= mem_rdata;
            end
          end else begin
            m_valid <= 1'b1;
            if (!lat_we) begin
              m_rdata <= mem_rdata;
            end
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a bench-side RAM model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        m_valid, m_err, m_stall;
  logic        l_req, l_we;
  logic [7:0]  l_addr;
  logic [63:0] l_wdata, l_rdata;
  logic        l_valid;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid), .m_err(m_err), .m_stall(m_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_valid(l_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data follows the address while mem_en is up, writes on
  // the clock edge; a backdoor port preloads contents.
  logic [63:0] ram [256];
  logic        bd_en;
  logic [7:0]  bd_addr;
  logic [63:0] bd_data;
  always @(posedge clk) begin
    if (bd_en) ram[bd_addr] <= bd_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [63:0] d);
    cyc();
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    cyc();
    bd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic found;
  logic exp_l;

  initial begin
    rst_n = 1'b0;
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    #2;
    // Reset state
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk64("rst_m_rdata", m_rdata, 64'h0);
    chk64("rst_mem_addr", 64'(mem_addr), 64'h0);
    preload(8'h10, 64'hDEADBEEF);
    preload(8'h00, 64'hAAAA);
    preload(8'h01, 64'h1111);
    preload(8'h02, 64'h2222);
    cyc();
    rst_n = 1'b1;

    // M read of 0x10
    cyc();
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h10;
    #1;
    chk1("rd_c1_stall", m_stall, 1'b1);
    chk1("rd_c1_mem_en", mem_en, 1'b0);
    cyc(); #1;
    chk1("rd_c2_mem_en", mem_en, 1'b1);
    chk1("rd_c2_mem_we", mem_we, 1'b0);
    chk64("rd_c2_mem_addr", 64'(mem_addr), 64'h10);
    chk1("rd_c2_stall", m_stall, 1'b1);
    chk1("rd_c2_valid", m_valid, 1'b0);
    cyc(); #1;
    chk1("rd_c3_valid", m_valid, 1'b1);
    chk64("rd_c3_rdata", m_rdata, 64'hDEADBEEF);
    chk1("rd_c3_stall", m_stall, 1'b0);
    chk1("rd_c3_err", m_err, 1'b0);
    chk1("rd_c3_mem_en", mem_en, 1'b0);
    m_req = 1'b0;
    cyc(); #1;
    chk1("rd_c4_valid", m_valid, 1'b0);

    // M write 0x1234 to 0x20, then read it back
    cyc();
    m_req = 1'b1; m_we = 1'b1; m_addr = 64'h20; m_wdata = 64'h1234;
    cyc(); #1;
    chk1("wr_c2_mem_en", mem_en, 1'b1);
    chk1("wr_c2_mem_we", mem_we, 1'b1);
    chk64("wr_c2_wdata", mem_wdata, 64'h1234);
    cyc(); #1;
    chk1("wr_c3_valid", m_valid, 1'b1);
    chk1("wr_c3_mem_we", mem_we, 1'b0);
    chk64("wr_c3_rdata_hold", m_rdata, 64'hDEADBEEF);
    chk64("wr_ram", ram[8'h20], 64'h1234);
    m_req = 1'b0;
    cyc();
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h20; m_wdata = 64'h0;
    cyc(); #1;
    chk1("rb_c2_mem_we", mem_we, 1'b0);
    chk1("rb_c2_mem_en", mem_en, 1'b1);
    cyc(); #1;
    chk1("rb_c3_valid", m_valid, 1'b1);
    chk64("rb_c3_rdata", m_rdata, 64'h1234);
    m_req = 1'b0;

    // Out-of-range write to 0x100
    cyc();
    m_req = 1'b1; m_we = 1'b1; m_addr = 64'h100; m_wdata = 64'h5555;
    #1;
    chk1("oor_c1_mem_en", mem_en, 1'b0);
    cyc(); #1;
    chk1("oor_c2_valid", m_valid, 1'b1);
    chk1("oor_c2_err", m_err, 1'b1);
    chk1("oor_c2_mem_en", mem_en, 1'b0);
    chk1("oor_c2_stall", m_stall, 1'b0);
    m_req = 1'b0;
    cyc(); #1;
    chk1("oor_c3_valid", m_valid, 1'b0);
    chk1("oor_c3_err", m_err, 1'b0);
    chk64("oor_ram0", ram[8'h00], 64'hAAAA);
    // Out-of-range read at all-ones
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc(); #1;
    chk1("oor2_valid", m_valid, 1'b1);
    chk1("oor2_err", m_err, 1'b1);
    chk1("oor2_mem_en", mem_en, 1'b0);
    chk64("oor2_rdata_hold", m_rdata, 64'h1234);
    m_req = 1'b0;

    // Contention: both held, M reads 0x01, L reads 0x02
    cyc();
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h01;
    l_req = 1'b1; l_we = 1'b0; l_addr = 8'h02;
    for (int g = 0; g < 10; g++) begin
      exp_l = (g == 4) || (g == 9);
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        cyc(); #1;
        if (m_valid || l_valid) found = 1'b1;
      end
      chk1($sformatf("cont%0d_seen", g), found, 1'b1);
      chk1($sformatf("cont%0d_l", g), l_valid, exp_l);
      chk1($sformatf("cont%0d_m", g), m_valid, !exp_l);
      if (exp_l) chk64($sformatf("cont%0d_lrdata", g), l_rdata, 64'h2222);
      else       chk64($sformatf("cont%0d_mrdata", g), m_rdata, 64'h1111);
    end
    m_req = 1'b0; l_req = 1'b0;

    // Simultaneous single-shot: M read 0x10, L write 0x3030 to 0x30
    cyc();
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h10;
    l_req = 1'b1; l_we = 1'b1; l_addr = 8'h30; l_wdata = 64'h3030;
    cyc();
    cyc(); #1;
    chk1("sim_c3_m", m_valid, 1'b1);
    chk1("sim_c3_l", l_valid, 1'b0);
    chk64("sim_c3_rdata", m_rdata, 64'hDEADBEEF);
    m_req = 1'b0;
    cyc(); #1;
    chk1("sim_c4_l", l_valid, 1'b0);
    cyc(); #1;
    chk1("sim_c5_mem_we", mem_we, 1'b1);
    chk64("sim_c5_addr", 64'(mem_addr), 64'h30);
    cyc(); #1;
    chk1("sim_c6_l", l_valid, 1'b1);
    chk1("sim_c6_m", m_valid, 1'b0);
    chk64("sim_ram30", ram[8'h30], 64'h3030);
    l_req = 1'b0;

    // Reset during ISSUE
    cyc();
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h10;
    cyc(); #1;
    chk1("rst_issue_mem_en", mem_en, 1'b1);
    rst_n = 1'b0;
    m_req = 1'b0;
    #1;
    chk1("rst_mid_mem_en", mem_en, 1'b0);
    chk64("rst_mid_mem_addr", 64'(mem_addr), 64'h0);
    chk64("rst_mid_m_rdata", m_rdata, 64'h0);
    chk64("rst_mid_l_rdata", l_rdata, 64'h0);
    chk1("rst_mid_valid", m_valid, 1'b0);
    cyc();
    chk1("rst_hold_valid", m_valid, 1'b0);
    rst_n = 1'b1;
    cyc();
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h20;
    cyc(); #1;
    chk1("post_c2_mem_en", mem_en, 1'b1);
    chk1("post_c2_valid", m_valid, 1'b0);
    cyc(); #1;
    chk1("post_c3_valid", m_valid, 1'b1);
    chk64("post_c3_rdata", m_rdata, 64'h1234);
    m_req = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
